// File: rtl/md_counter_ctrl_if.sv
// Command channel between a requester and the counter sequencer.
// The requester holds a command stable until cmd_ready is seen high.
interface md_counter_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_dir;
    logic             cmd_wrap;

    modport master (
        output cmd_valid, cmd_start, cmd_len, cmd_dir, cmd_wrap,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_len, cmd_dir, cmd_wrap,
        output cmd_ready
    );
endinterface

// File: rtl/md_counter_ctrl.sv
// Sequencer for a WIDTH-bit up/down counter: accepts run commands, paces steps
// through a prescaler and reports done / wrapped / saturated events.
module md_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int LEN_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    md_counter_ctrl_if.slave cmd,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrapped,
    output logic             sat
);
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [PSC_W-1:0] psc_q,     psc_d;
    logic [LEN_W-1:0] rem_q,     rem_d;
    logic             dir_q,     dir_d;
    logic             wrap_q,    wrap_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             wrapped_q, wrapped_d;
    logic             sat_q,     sat_d;

    logic             tick_s;
    logic             at_edge_s;
    logic [WIDTH-1:0] step_val_s;
    logic [LEN_W-1:0] rem_dec_s;

    // Next-state and next-output computation; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        psc_d      = psc_q;
        rem_d      = rem_q;
        dir_d      = dir_q;
        wrap_d     = wrap_q;
        done_d     = 1'b0;
        wrapped_d  = 1'b0;
        sat_d      = 1'b0;
        tick_s     = (psc_q == PSC_MAX) & ~pause;
        at_edge_s  = dir_q ? (count_q == {WIDTH{1'b0}}) : (count_q == {WIDTH{1'b1}});
        step_val_s = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        rem_dec_s  = rem_q - LEN_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    count_d = cmd.cmd_start;
                    psc_d   = {PSC_W{1'b0}};
                    rem_d   = cmd.cmd_len;
                    dir_d   = cmd.cmd_dir;
                    wrap_d  = cmd.cmd_wrap;
                    if (cmd.cmd_len == {LEN_W{1'b0}}) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort outranks any step, wrap or completion in the same cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (~pause) begin
                        psc_d = (psc_q == PSC_MAX) ? {PSC_W{1'b0}} : (psc_q + PSC_W'(1));
                    end else begin
                        psc_d = psc_q;
                    end
                    if (tick_s) begin
                        if (at_edge_s && !wrap_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            sat_d   = 1'b1;
                            rem_d   = {LEN_W{1'b0}};
                        end else begin
                            count_d   = step_val_s;
                            wrapped_d = at_edge_s;
                            rem_d     = rem_dec_s;
                            if (rem_dec_s == {LEN_W{1'b0}}) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= {WIDTH{1'b0}};
            psc_q     <= {PSC_W{1'b0}};
            rem_q     <= {LEN_W{1'b0}};
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            psc_q     <= psc_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
            sat_q     <= sat_d;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE) & rst;
    assign count         = count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign wrapped       = wrapped_q;
    assign sat           = sat_q;
endmodule

// File: tb/tb_md_counter_ctrl.sv
// Bench for md_counter_ctrl: two instances (PRESCALE 1 and 3) share one stimulus
// stream and are each compared every cycle against a behavioural model.
module tb_md_counter_ctrl;
    localparam int W = 4;
    localparam int L = 8;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, pause, abort;
    logic [W-1:0] count_o [2];
    logic busy_o [2];
    logic done_o [2];
    logic wrapped_o [2];
    logic sat_o [2];

    md_counter_ctrl_if #(.WIDTH(W), .LEN_W(L)) cif0 ();
    md_counter_ctrl_if #(.WIDTH(W), .LEN_W(L)) cif1 ();

    md_counter_ctrl #(.WIDTH(W), .LEN_W(L), .PRESCALE(1)) u_dut0 (
        .clk(clk), .rst(rst), .cmd(cif0.slave), .pause(pause), .abort(abort),
        .count(count_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .wrapped(wrapped_o[0]), .sat(sat_o[0])
    );
    md_counter_ctrl #(.WIDTH(W), .LEN_W(L), .PRESCALE(3)) u_dut1 (
        .clk(clk), .rst(rst), .cmd(cif1.slave), .pause(pause), .abort(abort),
        .count(count_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .wrapped(wrapped_o[1]), .sat(sat_o[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase, count as plain integers, steps left, active cycles.
    int presc [2] = '{1, 3};
    int m_phase [2];
    int m_count [2];
    int m_rem [2];
    int m_act [2];
    bit m_dir [2];
    bit m_wrap [2];
    bit m_busy [2];
    bit m_done [2];
    bit m_wrapped [2];
    bit m_sat [2];

    task automatic model_step(input int i, input bit v, input int st, input int ln,
                              input bit dr, input bit wr, input bit ps, input bit ab,
                              input bit r);
        int nxt;
        m_done[i] = 1'b0;
        m_wrapped[i] = 1'b0;
        m_sat[i] = 1'b0;
        if (!r) begin
            m_phase[i] = PH_IDLE;
            m_count[i] = 0;
            m_rem[i] = 0;
            m_act[i] = 0;
        end else if (m_phase[i] == PH_IDLE) begin
            if (v) begin
                m_count[i] = st;
                m_rem[i] = ln;
                m_act[i] = 0;
                m_dir[i] = dr;
                m_wrap[i] = wr;
                if (ln == 0) begin
                    m_phase[i] = PH_DONE;
                    m_done[i] = 1'b1;
                end else begin
                    m_phase[i] = PH_RUN;
                end
            end
        end else if (m_phase[i] == PH_RUN) begin
            if (ab) begin
                m_phase[i] = PH_IDLE;
            end else if (!ps) begin
                m_act[i]++;
                if (m_act[i] == presc[i]) begin
                    m_act[i] = 0;
                    nxt = m_count[i] + (m_dir[i] ? -1 : 1);
                    if (nxt < 0 || nxt >= (1 << W)) begin
                        if (m_wrap[i]) begin
                            m_count[i] = (nxt + (1 << W)) % (1 << W);
                            m_wrapped[i] = 1'b1;
                            m_rem[i]--;
                        end else begin
                            m_sat[i] = 1'b1;
                            m_done[i] = 1'b1;
                            m_phase[i] = PH_DONE;
                        end
                    end else begin
                        m_count[i] = nxt;
                        m_rem[i]--;
                    end
                    if (m_phase[i] == PH_RUN && m_rem[i] == 0) begin
                        m_phase[i] = PH_DONE;
                        m_done[i] = 1'b1;
                    end
                end
            end
        end else begin
            m_phase[i] = PH_IDLE;
        end
        m_busy[i] = (m_phase[i] == PH_RUN);
    endtask

    // One clock: check registered outputs, drive inputs, check cmd_ready, advance model.
    task automatic cyc(input bit v, input int st, input int ln, input bit dr, input bit wr,
                       input bit ps, input bit ab, input bit r);
        logic rdy;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("d%0d.count", i), 32'(count_o[i]), 32'(m_count[i]));
            check_val($sformatf("d%0d.busy", i), 32'(busy_o[i]), 32'(m_busy[i]));
            check_val($sformatf("d%0d.done", i), 32'(done_o[i]), 32'(m_done[i]));
            check_val($sformatf("d%0d.wrapped", i), 32'(wrapped_o[i]), 32'(m_wrapped[i]));
            check_val($sformatf("d%0d.sat", i), 32'(sat_o[i]), 32'(m_sat[i]));
        end
        rst = r;
        pause = ps;
        abort = ab;
        cif0.cmd_valid = v; cif0.cmd_start = W'(st); cif0.cmd_len = L'(ln);
        cif0.cmd_dir = dr;  cif0.cmd_wrap = wr;
        cif1.cmd_valid = v; cif1.cmd_start = W'(st); cif1.cmd_len = L'(ln);
        cif1.cmd_dir = dr;  cif1.cmd_wrap = wr;
        #1;
        for (int i = 0; i < 2; i++) begin
            rdy = (i == 0) ? cif0.cmd_ready : cif1.cmd_ready;
            check_val($sformatf("d%0d.cmd_ready", i), 32'(rdy),
                      32'((m_phase[i] == PH_IDLE) && r));
            model_step(i, v, st, ln, dr, wr, ps, ab, r);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit r, v, dr, wr, ps, ab;
        int st, ln;
        rst = 1'b0; pause = 1'b0; abort = 1'b0;
        cif0.cmd_valid = 1'b0; cif0.cmd_start = '0; cif0.cmd_len = '0;
        cif0.cmd_dir = 1'b0;   cif0.cmd_wrap = 1'b0;
        cif1.cmd_valid = 1'b0; cif1.cmd_start = '0; cif1.cmd_len = '0;
        cif1.cmd_dir = 1'b0;   cif1.cmd_wrap = 1'b0;
        for (int i = 0; i < 2; i++) model_step(i, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Up run with wrap enabled, no boundary crossing.
        cyc(1'b1, 3, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(18);
        check_val("t1.final0", 32'(count_o[0]), 32'd8);
        check_val("t1.final1", 32'(count_o[1]), 32'd8);

        // Up run crossing 15 -> 0.
        cyc(1'b1, 14, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(15);
        check_val("t2.final0", 32'(count_o[0]), 32'd2);

        // Down run saturating at 0.
        cyc(1'b1, 1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(10);
        check_val("t3.final0", 32'(count_o[0]), 32'd0);

        // Pause held mid-run freezes stepping and the prescaler.
        cyc(1'b1, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(8);
        check_val("t4.final1", 32'(count_o[1]), 32'd2);

        // Abort after three steps, then a fresh command.
        cyc(1'b1, 5, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check_val("t5.held0", 32'(count_o[0]), 32'd8);
        check_val("t5.ready0", 32'(cif0.cmd_ready), 32'd1);
        idle(2);
        cyc(1'b1, 9, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(10);

        // Reset in the middle of a run, then a load-only command.
        cyc(1'b1, 2, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t6.ready_rst", 32'(cif0.cmd_ready), 32'd0);
        idle(1);
        check_val("t6.count_rst", 32'(count_o[0]), 32'd0);
        cyc(1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_val("t6.load0", 32'(count_o[0]), 32'd7);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 2) == 0);
            st = int'($urandom_range(0, 15));
            ln = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            dr = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ps = ($urandom_range(0, 4) == 0);
            ab = ($urandom_range(0, 24) == 0);
            cyc(v, st, ln, dr, wr, ps, ab, r);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
